// File: rtl/axi_arbiter.sv
// ---------------------------------------------------------------------------
// axi_arbiter
//   Shares one AXI4-Lite slave port between two masters (m0 = instruction
//   fetch, m1 = load/store). Only one whole transaction is in flight at a
//   time: AR->R for a read, AW->W->B for a write. Arbitration happens in IDLE
//   and costs one cycle. On contention the arbiter uses round-robin
//   (RR_EN=1) or always picks FIXED_PRI_M (RR_EN=0).
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   m{0,1}_ar*/r*         read address / read data channels per master
//   m{0,1}_aw*/w*/b*      write address / data / response channels per master
//   s_*                   the same channels toward the crossbar
//   arb_gnt               one-hot grant of the active transaction, 0 in IDLE
//
// All slave-side and master-side muxing is combinational from the registered
// grant and state; nothing is buffered.
// ---------------------------------------------------------------------------
module axi_arbiter #(
  parameter int RR_EN       = 1,
  parameter int FIXED_PRI_M = 1
) (
  input  logic        clk,
  input  logic        reset,
  // master 0
  input  logic        m0_arvalid,
  input  logic [31:0] m0_araddr,
  output logic        m0_arready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_rresp,
  input  logic        m0_rready,
  input  logic        m0_awvalid,
  input  logic [31:0] m0_awaddr,
  output logic        m0_awready,
  input  logic        m0_wvalid,
  input  logic [31:0] m0_wdata,
  input  logic [7:0]  m0_wmask,
  output logic        m0_wready,
  output logic        m0_bvalid,
  output logic        m0_bresp,
  input  logic        m0_bready,
  // master 1
  input  logic        m1_arvalid,
  input  logic [31:0] m1_araddr,
  output logic        m1_arready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_rresp,
  input  logic        m1_rready,
  input  logic        m1_awvalid,
  input  logic [31:0] m1_awaddr,
  output logic        m1_awready,
  input  logic        m1_wvalid,
  input  logic [31:0] m1_wdata,
  input  logic [7:0]  m1_wmask,
  output logic        m1_wready,
  output logic        m1_bvalid,
  output logic        m1_bresp,
  input  logic        m1_bready,
  // slave side
  output logic        s_arvalid,
  output logic [31:0] s_araddr,
  input  logic        s_arready,
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  input  logic        s_rresp,
  output logic        s_rready,
  output logic        s_awvalid,
  output logic [31:0] s_awaddr,
  input  logic        s_awready,
  output logic        s_wvalid,
  output logic [31:0] s_wdata,
  output logic [7:0]  s_wmask,
  input  logic        s_wready,
  input  logic        s_bvalid,
  input  logic        s_bresp,
  output logic        s_bready,
  output logic [1:0]  arb_gnt
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t state_reg, state_next;
  logic   gnt_reg, gnt_next;     // index of the granted master
  logic   last_reg, last_next;   // index of the master served last

  // Signals of the currently granted master
  logic        sel_arvalid, sel_rready, sel_awvalid, sel_wvalid, sel_bready;
  logic [31:0] sel_araddr, sel_awaddr, sel_wdata;
  logic [7:0]  sel_wmask;

  // Handshake signals returned to whichever master is granted
  logic g_arready, g_rvalid, g_awready, g_wready, g_bvalid;

  logic req0, req1, winner, win_is_read;

  assign sel_arvalid = gnt_reg ? m1_arvalid : m0_arvalid;
  assign sel_araddr  = gnt_reg ? m1_araddr  : m0_araddr;
  assign sel_rready  = gnt_reg ? m1_rready  : m0_rready;
  assign sel_awvalid = gnt_reg ? m1_awvalid : m0_awvalid;
  assign sel_awaddr  = gnt_reg ? m1_awaddr  : m0_awaddr;
  assign sel_wvalid  = gnt_reg ? m1_wvalid  : m0_wvalid;
  assign sel_wdata   = gnt_reg ? m1_wdata   : m0_wdata;
  assign sel_wmask   = gnt_reg ? m1_wmask   : m0_wmask;
  assign sel_bready  = gnt_reg ? m1_bready  : m0_bready;

  assign req0 = m0_arvalid | m0_awvalid;
  assign req1 = m1_arvalid | m1_awvalid;

  // On a tie, round-robin favours the master that was not served last.
  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      if (RR_EN != 0) winner = ~last_reg;
      else            winner = (FIXED_PRI_M == 1);
    end
  end

  // A winner with both AR and AW pending is served its read first.
  assign win_is_read = winner ? m1_arvalid : m0_arvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      gnt_reg   <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    last_next  = last_reg;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    g_arready  = 1'b0;
    g_rvalid   = 1'b0;
    g_awready  = 1'b0;
    g_wready   = 1'b0;
    g_bvalid   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          gnt_next   = winner;
          state_next = win_is_read ? RD_ADDR : WR_ADDR;
        end
      end
      RD_ADDR: begin
        s_arvalid = sel_arvalid;
        g_arready = s_arready;
        if (sel_arvalid && s_arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        s_rready = sel_rready;
        g_rvalid = s_rvalid;
        if (s_rvalid && sel_rready) begin
          state_next = IDLE;
          last_next  = gnt_reg;
        end
      end
      WR_ADDR: begin
        s_awvalid = sel_awvalid;
        g_awready = s_awready;
        if (sel_awvalid && s_awready) state_next = WR_DATA;
      end
      WR_DATA: begin
        s_wvalid = sel_wvalid;
        g_wready = s_wready;
        if (sel_wvalid && s_wready) state_next = WR_RESP;
      end
      WR_RESP: begin
        s_bready = sel_bready;
        g_bvalid = s_bvalid;
        if (s_bvalid && sel_bready) begin
          state_next = IDLE;
          last_next  = gnt_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address/data toward the slave always follow the grant; only the valids
  // above qualify them.
  assign s_araddr = sel_araddr;
  assign s_awaddr = sel_awaddr;
  assign s_wdata  = sel_wdata;
  assign s_wmask  = sel_wmask;

  // Handshakes reach only the granted master; the other one sees zeros.
  assign m0_arready = g_arready & ~gnt_reg;
  assign m0_rvalid  = g_rvalid  & ~gnt_reg;
  assign m0_awready = g_awready & ~gnt_reg;
  assign m0_wready  = g_wready  & ~gnt_reg;
  assign m0_bvalid  = g_bvalid  & ~gnt_reg;
  assign m1_arready = g_arready &  gnt_reg;
  assign m1_rvalid  = g_rvalid  &  gnt_reg;
  assign m1_awready = g_awready &  gnt_reg;
  assign m1_wready  = g_wready  &  gnt_reg;
  assign m1_bvalid  = g_bvalid  &  gnt_reg;

  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_bresp = s_bresp;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_bresp = s_bresp;

  assign arb_gnt = (state_reg == IDLE) ? 2'b00 : (gnt_reg ? 2'b10 : 2'b01);

endmodule
